// File: rtl/pl_reg_elastic.sv
// Elastic pipeline stage register: valid/ready handshake, 2-entry skid buffer,
// flush-driven bubble insertion and saturating stall/bubble performance counters.
module pl_reg_elastic #(
    parameter int unsigned CTRL_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [CTRL_WIDTH-1:0] ctrl_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [CTRL_WIDTH-1:0] ctrl_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  cnt_clr_i,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  bubble_cnt_o
);

    // State bits are the entry valid bits: [1] = skid valid, [0] = main valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CTRL_WIDTH-1:0] r_main_ctrl;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic [CTRL_WIDTH-1:0] r_skid_ctrl;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;
    logic [CNT_WIDTH-1:0]  r_bubble_cnt;

    logic w_in_fire;
    logic w_out_fire;
    logic w_main_ld_in;
    logic w_main_ld_skid;
    logic w_main_clr;
    logic w_skid_ld;
    logic w_skid_clr;

    assign ready_o      = (r_state != ST_FULL);
    assign valid_o      = r_state[0];
    assign ctrl_o       = r_main_ctrl;
    assign data_o       = r_main_data;
    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;

    assign w_in_fire  = valid_i & ready_o & ~flush_i;
    assign w_out_fire = valid_o & ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Next state and per-entry load/clear strobes; flush empties the stage.
    always_comb begin
        w_state_nxt    = r_state;
        w_main_ld_in   = 1'b0;
        w_main_ld_skid = 1'b0;
        w_main_clr     = 1'b0;
        w_skid_ld      = 1'b0;
        w_skid_clr     = 1'b0;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
            w_main_clr  = 1'b1;
            w_skid_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt  = ST_ONE;
                        w_main_ld_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_ld_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt = ST_FULL;
                        w_skid_ld   = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                        w_main_clr  = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt    = ST_ONE;
                        w_main_ld_skid = 1'b1;
                        w_skid_clr     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_clr  = 1'b1;
                    w_skid_clr  = 1'b1;
                end
            endcase
        end
    end

    // Control fields zero whenever their entry goes invalid; data only ever loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_main_clr)          r_main_ctrl <= '0;
            else if (w_main_ld_in)   r_main_ctrl <= ctrl_i;
            else if (w_main_ld_skid) r_main_ctrl <= r_skid_ctrl;

            if (w_main_ld_in)        r_main_data <= data_i;
            else if (w_main_ld_skid) r_main_data <= r_skid_data;

            if (w_skid_clr)          r_skid_ctrl <= '0;
            else if (w_skid_ld)      r_skid_ctrl <= ctrl_i;

            if (w_skid_ld)           r_skid_data <= data_i;
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (valid_o && !ready_i && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            if (!valid_o && ready_i && (r_bubble_cnt != CNT_MAX))
                r_bubble_cnt <= r_bubble_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
